fu_wb_collector: RTL and testbench

Receiving end of the functional-unit result interface. Accepts the fire-and-forget fu_output_t / valid streams from NFU functional units (divider, multiplier, ALUs), which have no output ready. Buffers each stream in a private FIFO and round-robin arbitrates the buffered results onto one back-pressured writeback port toward the register file and ROB. Flushes on squash exactly like the FUs it serves.

---
 rtl/fu_wb_collector_pkg.sv | 26 ++
 rtl/squash_if.sv | 7 +
 rtl/fu_wb_collector_wb_fifo.sv | 83 ++++++++
 rtl/fu_wb_collector.sv | 97 +++++++++
 tb/tb_fu_wb_collector.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/fu_wb_collector_pkg.sv
// Shared types for the functional-unit writeback collector.
//   fu_output_t   : one FU result (pc, instruction id, physical dest, value)
//   WB_*          : default collector sizing
//   fu_idx_t      : index of one FU result stream at the default NFU
//   wb_fifo_cnt_t : per-FIFO occupancy (0..DEPTH) at the default DEPTH
package fu_wb_collector_pkg;

    localparam int XLEN  = 32;
    localparam int ID_W  = 5;
    localparam int PRD_W = 6;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [ID_W-1:0]  id;
        logic [PRD_W-1:0] prd;
        logic [XLEN-1:0]  rdval;
    } fu_output_t;

    localparam int WB_NFU   = 4;
    localparam int WB_DEPTH = 4;
    localparam int WB_SLACK = 1;

    typedef logic [$clog2(WB_NFU)-1:0] fu_idx_t;
    typedef logic [$clog2(WB_DEPTH):0] wb_fifo_cnt_t;

endpackage

// File: rtl/squash_if.sv
// Pipeline squash broadcast. The master raises valid for one or more cycles;
// every slave flushes its in-flight state at the following clock edge.
interface squash_if;
    logic valid;
    modport master (output valid);
    modport slave  (input  valid);
endinterface

// File: rtl/fu_wb_collector_wb_fifo.sv
// wb_fifo: single-stream result FIFO for one functional unit.
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : drop all entries at the next edge (push/pop that cycle ignored)
//   push        : write push_data this edge (no ready upstream)
//   pop         : remove head this edge (ignored when empty)
//   head        : current head entry (valid when !empty)
//   empty       : FIFO holds no entries
//   full_hint   : registered (count >= DEPTH-SLACK), based on next-state count
//   overflow    : sticky, a push hit a full FIFO with no pop and was dropped
module wb_fifo
    import fu_wb_collector_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int SLACK = WB_SLACK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  fu_output_t push_data,
    input  logic       pop,
    output fu_output_t head,
    output logic       empty,
    output logic       full_hint,
    output logic       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(DEPTH - SLACK);

    fu_output_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_full, do_push, do_pop, drop;

    always_comb begin
        is_full = (cnt_q == CNT_MAX);
        do_pop  = pop && !flush && (cnt_q != '0);
        // A full FIFO still accepts a push when its head leaves the same edge.
        do_push = push && !flush && (!is_full || do_pop);
        drop    = push && !flush && is_full && !do_pop;
        cnt_d   = cnt_q;
        if (flush)
            cnt_d = '0;
        else if (do_push && !do_pop)
            cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            full_hint <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            cnt_q     <= cnt_d;
            full_hint <= (cnt_d >= CNT_THR);
            // Survives flush: a lost result is a hard error the core must see.
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage carries no reset; an entry is only observable once pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/fu_wb_collector.sv
// fu_wb_collector: buffers fire-and-forget FU result streams and round-robin
// arbitrates them onto one back-pressured writeback port.
//   clk, rst          : clock, asynchronous active-high reset
//   fuoutput_i        : per-FU result
//   fuoutput_i_valid  : per-FU result valid (no ready; accepted or flagged)
//   fu_full_o         : per-FU stop-issue hint
//   wb_o, wb_o_valid  : selected result (combinational from FIFO heads)
//   wb_i_ready        : consumer takes wb_o this cycle
//   overflow_o        : per-FU sticky drop flag (cleared by reset only)
//   squash_io         : squash_io.valid flushes all FIFOs and the arbiter
module fu_wb_collector
    import fu_wb_collector_pkg::*;
#(
    parameter int NFU   = WB_NFU,
    parameter int DEPTH = WB_DEPTH,
    parameter int SLACK = WB_SLACK
) (
    input  logic                 clk,
    input  logic                 rst,
    input  fu_output_t [NFU-1:0] fuoutput_i,
    input  logic [NFU-1:0]       fuoutput_i_valid,
    output logic [NFU-1:0]       fu_full_o,
    output fu_output_t           wb_o,
    output logic                 wb_o_valid,
    input  logic                 wb_i_ready,
    output logic [NFU-1:0]       overflow_o,
    squash_if.slave              squash_io
);

    localparam int IDX_W = (NFU > 1) ? $clog2(NFU) : 1;

    fu_output_t [NFU-1:0] head;
    logic [NFU-1:0]       empty;
    logic [NFU-1:0]       pop;
    logic [IDX_W-1:0]     rr_q, gnt, gnt_inc;
    logic                 any, fire, flush;

    assign flush = squash_io.valid;

    for (genvar g = 0; g < NFU; g++) begin : g_fu
        assign pop[g] = fire && (gnt == IDX_W'(g));

        wb_fifo #(
            .DEPTH (DEPTH),
            .SLACK (SLACK)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .push      (fuoutput_i_valid[g]),
            .push_data (fuoutput_i[g]),
            .pop       (pop[g]),
            .head      (head[g]),
            .empty     (empty[g]),
            .full_hint (fu_full_o[g]),
            .overflow  (overflow_o[g])
        );
    end

    // First non-empty FIFO at or after rr_q, wrapping at NFU-1 -> 0.
    always_comb begin
        int idx;
        idx = 0;
        gnt = rr_q;
        any = 1'b0;
        for (int k = 0; k < NFU; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NFU) idx = idx - NFU;
            if (!any && !empty[idx]) begin
                gnt = IDX_W'(idx);
                any = 1'b1;
            end
        end
        gnt_inc = (int'(gnt) == NFU - 1) ? '0 : gnt + 1'b1;
    end

    assign wb_o_valid = any;
    assign wb_o       = any ? head[gnt] : '0;
    assign fire       = any && wb_i_ready;

    // While stalled, rr_q is parked on the current grant. A granted FIFO
    // cannot empty without a pop, so the search keeps landing on it even if
    // a FIFO earlier in the old search order becomes non-empty meanwhile;
    // that keeps wb_o stable without a separate grant lock. After the pop
    // rr_q advances past the grant, so the visible order is plain round robin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_q <= '0;
        else if (flush)
            rr_q <= '0;
        else if (fire)
            rr_q <= gnt_inc;
        else if (any)
            rr_q <= gnt;
    end

endmodule

// File: tb/tb_fu_wb_collector.sv
module tb_fu_wb_collector;
    import fu_wb_collector_pkg::*;

    localparam int NFU = 4;

    logic                 clk;
    logic                 rst;
    fu_output_t [NFU-1:0] fuin;
    logic [NFU-1:0]       vld;
    logic [NFU-1:0]       fu_full;
    fu_output_t           wb_o;
    logic                 wb_o_valid;
    logic                 ready;
    logic [NFU-1:0]       ovf;

    squash_if sq ();

    fu_wb_collector #(.NFU(NFU), .DEPTH(4), .SLACK(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .fuoutput_i       (fuin),
        .fuoutput_i_valid (vld),
        .fu_full_o        (fu_full),
        .wb_o             (wb_o),
        .wb_o_valid       (wb_o_valid),
        .wb_i_ready       (ready),
        .overflow_o       (ovf),
        .squash_io        (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic fu_output_t mk(input logic [31:0] pc, input logic [4:0] id,
                                      input logic [5:0] prd, input logic [31:0] rd);
        fu_output_t r;
        r.pc = pc; r.id = id; r.prd = prd; r.rdval = rd;
        return r;
    endfunction

    // Advance one edge; outputs are sampled 1ns later, inputs changed then.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    fu_output_t a, b, c, d, e, q, t;
    fu_output_t r [5];
    fu_output_t p [5];
    fu_output_t s [4];

    initial begin
        rst = 1'b1; vld = '0; ready = 1'b0; fuin = '0; sq.valid = 1'b0;
        step(); step();
        chk("rst_vld",  128'(wb_o_valid), 128'(0));
        chk("rst_wb",   128'(wb_o),       128'(0));
        chk("rst_full", 128'(fu_full),    128'(0));
        chk("rst_ovf",  128'(ovf),        128'(0));
        rst = 1'b0;

        // single result from FU1
        a = mk(32'h100, 5'd3, 6'd7, 32'h2A);
        ready = 1'b1; fuin[1] = a; vld = 4'b0010;
        step(); vld = '0;
        chk("t1_vld",  128'(wb_o_valid), 128'(1));
        chk("t1_data", 128'(wb_o),       128'(a));
        step();
        chk("t1_done", 128'(wb_o_valid), 128'(0));

        // FU0 and FU2 together with rr_q=0
        do_reset();
        b = mk(32'h200, 5'd1, 6'd1, 32'h11);
        c = mk(32'h204, 5'd2, 6'd2, 32'h22);
        fuin[0] = b; fuin[2] = c; vld = 4'b0101;
        step(); vld = '0;
        chk("t2_first",  128'(wb_o), 128'(b));
        step();
        chk("t2_second", 128'(wb_o), 128'(c));
        step();
        chk("t2_empty",  128'(wb_o_valid), 128'(0));
        // rr_q is now 3: FU3 wins over FU0 pushed in the same cycle
        ready = 1'b0;
        d = mk(32'h300, 5'd4, 6'd4, 32'h33);
        e = mk(32'h304, 5'd5, 6'd5, 32'h44);
        fuin[0] = d; fuin[3] = e; vld = 4'b1001;
        step(); vld = '0;
        chk("t2_rr3", 128'(wb_o), 128'(e));
        q = mk(32'h308, 5'd6, 6'd6, 32'h55);
        fuin[1] = q; vld = 4'b0010;
        step(); vld = '0;
        chk("t2_hold", 128'(wb_o), 128'(e));
        ready = 1'b1;
        step();
        chk("t2_wrap0", 128'(wb_o), 128'(d));
        step();
        chk("t2_fu1",   128'(wb_o), 128'(q));
        step();
        chk("t2_drain", 128'(wb_o_valid), 128'(0));

        // FU3 fills under back-pressure, then push+pop while full
        ready = 1'b0;
        for (int k = 0; k < 5; k++)
            r[k] = mk(32'h400 + 32'(4*k), 5'(k + 8), 6'(k + 10), 32'h1000 + 32'(k));
        for (int k = 0; k < 4; k++) begin
            fuin[3] = r[k]; vld = 4'b1000;
            step(); vld = '0;
            chk($sformatf("t3_full%0d", k), 128'(fu_full[3]), 128'(k >= 2));
            chk($sformatf("t3_head%0d", k), 128'(wb_o), 128'(r[0]));
        end
        ready = 1'b1; fuin[3] = r[4]; vld = 4'b1000;
        step(); vld = '0;
        chk("t3_pp_data", 128'(wb_o),    128'(r[1]));
        chk("t3_pp_full", 128'(fu_full), 128'(4'b1000));
        chk("t3_pp_ovf",  128'(ovf),     128'(0));
        for (int k = 2; k < 5; k++) begin
            step();
            chk($sformatf("t3_drain%0d", k), 128'(wb_o), 128'(r[k]));
        end
        step();
        chk("t3_empty", 128'(wb_o_valid), 128'(0));
        chk("t3_nfull", 128'(fu_full),    128'(0));

        // FU0 overflow
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            p[k] = mk(32'h500 + 32'(4*k), 5'(k + 16), 6'(k + 20), 32'h2000 + 32'(k));
            fuin[0] = p[k]; vld = 4'b0001;
            step(); vld = '0;
        end
        chk("t4_ovf",  128'(ovf),     128'(4'b0001));
        chk("t4_head", 128'(wb_o),    128'(p[0]));
        chk("t4_full", 128'(fu_full), 128'(4'b0001));

        // squash with three FIFOs occupied and a concurrent FU1 push
        fuin[2] = c; fuin[3] = e; vld = 4'b1100;
        step(); vld = '0;
        chk("t5_pre", 128'(fu_full), 128'(4'b0001));
        sq.valid = 1'b1; fuin[1] = a; vld = 4'b0010;
        step(); sq.valid = 1'b0; vld = '0;
        chk("t5_vld",  128'(wb_o_valid), 128'(0));
        chk("t5_full", 128'(fu_full),    128'(0));
        chk("t5_ovf",  128'(ovf),        128'(4'b0001));
        step();
        chk("t5_lost", 128'(wb_o_valid), 128'(0));

        // asynchronous reset in the middle of a drain
        for (int k = 0; k < 4; k++) begin
            s[k] = mk(32'h600 + 32'(4*k), 5'(k + 24), 6'(k + 30), 32'h3000 + 32'(k));
            fuin[2] = s[k]; vld = 4'b0100;
            step(); vld = '0;
        end
        ready = 1'b1;
        step();
        chk("t6_mid",  128'(wb_o),    128'(s[1]));
        chk("t6_full", 128'(fu_full), 128'(4'b0100));
        #3 rst = 1'b1;
        #1;
        chk("t6_async_vld",  128'(wb_o_valid), 128'(0));
        chk("t6_async_full", 128'(fu_full),    128'(0));
        chk("t6_async_ovf",  128'(ovf),        128'(0));
        #1 rst = 1'b0;
        t = mk(32'h700, 5'd31, 6'd63, 32'hDEAD_BEEF);
        fuin[1] = t; vld = 4'b0010;
        step(); vld = '0;
        chk("t6_next",  128'(wb_o), 128'(t));
        step();
        chk("t6_empty", 128'(wb_o_valid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
